count_tick_ctrl: RTL and testbench

COUNT_TICK_CTRL -- requirements
Module: count_tick_ctrl

---
 rtl/count_tick_ctrl_pkg.sv | 30 +++
 rtl/count_tick_ctrl_prescaler.sv | 46 ++++
 rtl/count_tick_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_count_tick_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_tick_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// count_tick_ctrl_pkg
//   Shared definitions for the count/tick controller slice:
//     - default widths for the prescaler period and the burst length
//     - the controller state encoding
//     - a small helper giving the number of ticks in a burst
// -----------------------------------------------------------------------------
package count_tick_ctrl_pkg;

    // Default width of the prescaler period (ticks every period+1 cycles).
    localparam int DIV_W_DEF   = 8;

    // Default width of the burst length (a burst emits burst_len+1 ticks).
    localparam int BURST_W_DEF = 4;

    // Controller states. The numeric encoding is fixed so that it can be
    // observed and compared against other tools in the flow.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // True for the states in which the controller reports itself busy.
    function automatic logic state_is_busy(input state_t s);
        return (s == ST_CLEAR) || (s == ST_RUN);
    endfunction

endpackage : count_tick_ctrl_pkg

// File: rtl/count_tick_ctrl_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
//   Free-running divide-by-(period+1) counter used by count_tick_ctrl.
//   While en is low the count is held at zero, so the first terminal count
//   after en rises arrives exactly period+1 enabled cycles later.
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   synchronous, active-low reset
//   en      in   count enable; low clears the count
//   period  in   terminal value; tc fires when the count equals it
//   tc      out  terminal count (combinational, qualified by en)
// -----------------------------------------------------------------------------
module tick_prescaler
    import count_tick_ctrl_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] period,
    output logic             tc
);

    logic [DIV_W-1:0] count;

    // Terminal count. With period=0 this is high on every enabled cycle.
    assign tc = en && (count == period);

    // NOTE: sequential state is assigned with non-blocking (<=) so every
    // register samples the pre-edge values of its inputs, independent of the
    // order in which always blocks are evaluated.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (!en || tc) begin
            // Reload on terminal count; also covers period=all-ones, where the
            // count would otherwise wrap naturally.
            count <= '0;
        end else begin
            count <= count + DIV_W'(1);
        end
    end

endmodule : tick_prescaler

// File: rtl/count_tick_ctrl.sv
// -----------------------------------------------------------------------------
// count_tick_ctrl
//   Controller that drives a downstream up-counter with a one-cycle clear
//   pulse (cnt_clr) followed by periodic count-enable pulses (tick).
//
//   A run starts from IDLE on start=1 (with stop=0). The configuration
//   (period, burst_len, single) is captured on that edge and held for the
//   whole run. The controller then spends one cycle in CLEAR (cnt_clr=1)
//   and moves to RUN, where a tick is emitted every period+1 cycles.
//     single=0 : continuous; RUN lasts until stop.
//     single=1 : burst; after burst_len+1 ticks the controller spends one
//                cycle in DONE (done=1) and returns to IDLE.
//   stop in CLEAR or RUN aborts to IDLE without a done pulse.
//
//   All outputs are registered and line up with the state they describe:
//   cnt_clr is high in the CLEAR cycle, busy in CLEAR and RUN, done in the
//   DONE cycle.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-low reset
//   start      in   begin a run (sampled only in IDLE)
//   stop       in   abort the run (sampled in CLEAR and RUN)
//   single     in   1 = burst mode, 0 = continuous (latched at start)
//   period     in   tick spacing minus one (latched at start)
//   burst_len  in   ticks per burst minus one (latched at start)
//   cnt_clr    out  one-cycle clear pulse for the downstream counter
//   tick       out  one-cycle count enable for the downstream counter
//   busy       out  high in CLEAR and RUN
//   done       out  one-cycle pulse on burst completion
// -----------------------------------------------------------------------------
module count_tick_ctrl
    import count_tick_ctrl_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEF,
    parameter int BURST_W = BURST_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               single,
    input  logic [DIV_W-1:0]   period,
    input  logic [BURST_W-1:0] burst_len,
    output logic               cnt_clr,
    output logic               tick,
    output logic               busy,
    output logic               done
);

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    state_t               state;
    state_t               state_nx;

    // Configuration captured at start.
    logic [DIV_W-1:0]     period_l;
    logic [BURST_W-1:0]   burst_len_l;
    logic                 single_l;

    // Ticks emitted in the current burst. One bit wider than burst_len so
    // that burst_len+1 (up to 2**BURST_W) is representable.
    logic [BURST_W:0]     tick_cnt;
    logic [BURST_W:0]     burst_target;
    logic                 burst_full;

    logic                 prescale_en;
    logic                 tc;
    logic                 run_accept;

    // Next values of the registered outputs.
    logic                 cnt_clr_d;
    logic                 tick_d;
    logic                 busy_d;
    logic                 done_d;

    // -------------------------------------------------------------------------
    // Prescaler
    // -------------------------------------------------------------------------
    // Enabled only in RUN, so it sits at zero through IDLE and CLEAR and the
    // first terminal count lands period+1 cycles after RUN is entered.
    assign prescale_en = (state == ST_RUN);

    tick_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .en     (prescale_en),
        .period (period_l),
        .tc     (tc)
    );

    // -------------------------------------------------------------------------
    // Burst bookkeeping
    // -------------------------------------------------------------------------
    assign burst_target = {1'b0, burst_len_l} + (BURST_W+1)'(1);

    // The last tick of a burst is registered on the edge that makes tick_cnt
    // reach the target, so burst_full is seen during that tick's cycle. RUN
    // then hands over to DONE and any further terminal count is ignored.
    assign burst_full   = single_l && (tick_cnt == burst_target);

    // A run is accepted only from IDLE and only without a concurrent stop.
    assign run_accept   = (state == ST_IDLE) && start && !stop;

    // -------------------------------------------------------------------------
    // FSM: state register (and registered outputs)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt_clr <= 1'b0;
            tick    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt_clr <= cnt_clr_d;
            tick    <= tick_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal written in an always_comb gets a default at the top,
    // so no path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (run_accept) begin
                    state_nx = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_nx = stop ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                if (stop) begin
                    state_nx = ST_IDLE;
                end else if (burst_full) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: output logic (values registered on the next edge)
    // -------------------------------------------------------------------------
    // cnt_clr/busy/done follow the state being entered, so the registered
    // outputs describe the state of the same cycle. tick follows the terminal
    // count; stop suppresses it, and it can only arise in RUN, which keeps it
    // disjoint from cnt_clr (asserted only for CLEAR).
    always_comb begin
        cnt_clr_d = (state_nx == ST_CLEAR);
        busy_d    = state_is_busy(state_nx);
        done_d    = (state_nx == ST_DONE);
        tick_d    = 1'b0;
        if ((state == ST_RUN) && !stop && !burst_full && tc) begin
            tick_d = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Configuration capture and tick counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            period_l    <= '0;
            burst_len_l <= '0;
            single_l    <= 1'b0;
        end else if (run_accept) begin
            period_l    <= period;
            burst_len_l <= burst_len;
            single_l    <= single;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            tick_cnt <= '0;
        end else if (tick_d && single_l) begin
            // Only bursts need the count; continuous runs leave it alone so
            // it cannot wrap during an arbitrarily long run.
            tick_cnt <= tick_cnt + (BURST_W+1)'(1);
        end
    end

endmodule : count_tick_ctrl

// File: tb/tb_count_tick_ctrl.sv
// -----------------------------------------------------------------------------
// tb_count_tick_ctrl
//   Self-checking bench for count_tick_ctrl. A reference model describes a run
//   arithmetically: k counts cycles since the start edge (k=1 is the clear
//   cycle), ticks fall where k-2 is a positive multiple of period+1, and a
//   burst ends after burst_len+1 of them with one done cycle.
// -----------------------------------------------------------------------------
module tb_count_tick_ctrl;

    localparam int DIV_W   = 8;
    localparam int BURST_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               stop;
    logic               single;
    logic [DIV_W-1:0]   period;
    logic [BURST_W-1:0] burst_len;
    logic               cnt_clr;
    logic               tick;
    logic               busy;
    logic               done;

    count_tick_ctrl #(
        .DIV_W   (DIV_W),
        .BURST_W (BURST_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .single    (single),
        .period    (period),
        .burst_len (burst_len),
        .cnt_clr   (cnt_clr),
        .tick      (tick),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model
    bit m_active;
    int m_k;
    int m_p;
    int m_bl;
    bit m_single;

    // Bench-side observation
    int       cyc = 0;
    int       last_tick_cyc = 0;
    int       tick_gap = 0;
    int       ticks_seen = 0;
    int       dones_seen = 0;
    logic [3:0] cnt4 = 4'd0;

    function automatic int last_tick_k();
        return 2 + (m_bl + 1) * (m_p + 1);
    endfunction

    function automatic bit e_busy();
        return m_active && (!m_single || m_k <= last_tick_k());
    endfunction

    function automatic bit e_clr();
        return m_active && (m_k == 1);
    endfunction

    function automatic bit e_tick();
        if (!m_active || m_k < 3) return 1'b0;
        if (((m_k - 2) % (m_p + 1)) != 0) return 1'b0;
        return !m_single || (((m_k - 2) / (m_p + 1)) <= m_bl + 1);
    endfunction

    function automatic bit e_done();
        return m_active && m_single && (m_k == last_tick_k() + 1);
    endfunction

    // Advance the model by one clock edge using the inputs presented at it.
    task automatic model_edge();
        if (!rst) begin
            m_active = 1'b0;
        end else if (m_active) begin
            if (stop && e_busy()) begin
                m_active = 1'b0;
            end else begin
                m_k++;
                if (m_single && m_k > last_tick_k() + 1) m_active = 1'b0;
            end
        end else if (start && !stop) begin
            m_active = 1'b1;
            m_k      = 1;
            m_p      = int'(period);
            m_bl     = int'(burst_len);
            m_single = single;
        end
    endtask

    // One clock: model update at the edge, outputs compared 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        checks++;
        if (cnt_clr !== e_clr()) begin
            errors++;
            $display("FAIL cnt_clr cyc=%0d got=%b exp=%b", cyc, cnt_clr, e_clr());
        end
        checks++;
        if (tick !== e_tick()) begin
            errors++;
            $display("FAIL tick cyc=%0d got=%b exp=%b", cyc, tick, e_tick());
        end
        checks++;
        if (busy !== e_busy()) begin
            errors++;
            $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy());
        end
        checks++;
        if (done !== e_done()) begin
            errors++;
            $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, e_done());
        end
        checks++;
        if (tick === 1'b1 && cnt_clr === 1'b1) begin
            errors++;
            $display("FAIL tick_clr_overlap cyc=%0d got=both exp=exclusive", cyc);
        end
        if (cnt_clr === 1'b1) cnt4 = 4'd0;
        else if (tick === 1'b1) cnt4 = cnt4 + 4'd1;
        if (tick === 1'b1) begin
            tick_gap      = cyc - last_tick_cyc;
            last_tick_cyc = cyc;
            ticks_seen++;
        end
        if (done === 1'b1) dones_seen++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic begin_run(input int p, input int bl, input bit sgl);
        period    = DIV_W'(p);
        burst_len = BURST_W'(bl);
        single    = sgl;
        start     = 1'b1;
        step();
        start     = 1'b0;
        ticks_seen = 0;
        dones_seen = 0;
    endtask

    task automatic end_run();
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if (tick !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_effect got tick=%b busy=%b exp tick=0 busy=0", tick, busy);
        end
        step();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b0; start = 1'b0; stop = 1'b0; single = 1'b0;
        period = '0; burst_len = '0;
        run(3);
        checks++;
        if ({cnt_clr, tick, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=0000", {cnt_clr, tick, busy, done});
        end
        rst = 1'b1;
        run(2);
    endtask

    task automatic test_continuous();
        begin_run(0, 0, 1'b0);
        checks++;
        if (cnt_clr !== 1'b1) begin
            errors++;
            $display("FAIL cont_clr got=%b exp=1", cnt_clr);
        end
        // Configuration changes mid-run must not matter.
        period = 8'd7; single = 1'b1; burst_len = 4'd1;
        run(12);
        checks++;
        if (ticks_seen != 11 || busy !== 1'b1) begin
            errors++;
            $display("FAIL cont_ticks got=%0d busy=%b exp=11 busy=1", ticks_seen, busy);
        end
        end_run();
    endtask

    task automatic test_burst();
        int gap_bad = 0;
        begin_run(3, 2, 1'b1);
        period = 8'd0; burst_len = 4'd9; single = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (tick === 1'b1 && ticks_seen > 1 && tick_gap != 4) gap_bad++;
        end
        checks++;
        if (ticks_seen != 3 || dones_seen != 1 || gap_bad != 0) begin
            errors++;
            $display("FAIL burst_shape got ticks=%0d dones=%0d badgaps=%0d exp 3 1 0",
                     ticks_seen, dones_seen, gap_bad);
        end
        checks++;
        if (cnt4 !== 4'd3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL burst_count got cnt=%0d busy=%b exp cnt=3 busy=0", cnt4, busy);
        end
    endtask

    task automatic test_stop_burst();
        int budget = 0;
        begin_run(1, 7, 1'b1);
        while (ticks_seen < 2 && budget < 40) begin
            step();
            budget++;
        end
        checks++;
        if (ticks_seen != 2) begin
            errors++;
            $display("FAIL stop_burst_wait got ticks=%0d exp=2", ticks_seen);
        end
        end_run();
        ticks_seen = 0;
        run(20);
        checks++;
        if (ticks_seen != 0 || dones_seen != 0) begin
            errors++;
            $display("FAIL stop_burst_after got ticks=%0d dones=%0d exp 0 0", ticks_seen, dones_seen);
        end
    endtask

    task automatic test_mid_reset();
        int first = -1;
        begin_run(2, 0, 1'b0);
        run(8);
        rst = 1'b0;
        step();
        checks++;
        if ({cnt_clr, tick, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_outputs got=%b exp=0000", {cnt_clr, tick, busy, done});
        end
        rst = 1'b1;
        run(2);
        begin_run(2, 0, 1'b0);
        for (int i = 2; i <= 10 && first < 0; i++) begin
            step();
            if (tick === 1'b1) first = i;
        end
        checks++;
        if (first != 5) begin
            errors++;
            $display("FAIL midreset_first_tick got=%0d exp=5", first);
        end
        end_run();
    endtask

    task automatic test_start_stop();
        int gap_bad = 0;
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || cnt_clr !== 1'b0) begin
            errors++;
            $display("FAIL start_stop_idle got busy=%b clr=%b exp 0 0", busy, cnt_clr);
        end
        run(2);
        begin_run(1, 0, 1'b0);
        run(6);
        period = 8'd5; start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (tick === 1'b1 && tick_gap != 2) gap_bad++;
        end
        start = 1'b0;
        checks++;
        if (gap_bad != 0) begin
            errors++;
            $display("FAIL restart_gap got badgaps=%0d exp=0", gap_bad);
        end
        end_run();
    endtask

    task automatic test_wrap();
        int gap_bad = 0;
        int budget  = 0;
        begin_run(255, 0, 1'b0);
        while (ticks_seen < 4 && budget < 1100) begin
            step();
            budget++;
            if (tick === 1'b1 && ticks_seen > 1 && tick_gap != 256) gap_bad++;
        end
        checks++;
        if (ticks_seen != 4 || gap_bad != 0) begin
            errors++;
            $display("FAIL wrap got ticks=%0d badgaps=%0d exp 4 0", ticks_seen, gap_bad);
        end
        end_run();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(199) != 0);
            start     = ($urandom_range(7) == 0);
            stop      = ($urandom_range(39) == 0);
            single    = $urandom_range(1);
            period    = ($urandom_range(3) == 0) ? DIV_W'($urandom) : DIV_W'($urandom_range(5));
            burst_len = BURST_W'($urandom);
            step();
        end
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        run(2);
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_burst();
        test_stop_burst();
        test_mid_reset();
        test_start_stop();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_count_tick_ctrl
